// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch path, the load/store path, the shared memory
// port and the arbiter. The arbiter connects through the slave modport and
// the surrounding core or memory model connects through the master modport.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              owner;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, busy, owner
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins arbitration unless fetch has waited through STARVE_MAX data grants.
//
// state   | meaning
// IDLE    | no transaction; arbitrate requests this cycle
// BUSY_IF | fetch request on the memory port, waiting for mem_ack
// BUSY_D  | data request on the memory port, waiting for mem_ack
// RESP    | one-cycle completion pulse to the owner; requests ignored
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            state_q,      state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              owner_q,      owner_d;
   logic              mem_req_q,    mem_req_d;
   logic              mem_we_q,     mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic              if_ready_q,   if_ready_d;
   logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
   logic              d_ready_q,    d_ready_d;
   logic              d_rvalid_q,   d_rvalid_d;
   logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

   // Arbitration, memory request launch and completion capture.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      owner_d      = owner_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_ready_d   = 1'b0;
      d_ready_d    = 1'b0;
      d_rvalid_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.d_req && (!bus.if_req || (starve_cnt_q < STARVE_LIM))) begin
               state_d     = BUSY_D;
               owner_d     = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               if (!bus.if_req) begin
                  starve_cnt_d = 4'd0;
               end else if (starve_cnt_q != STARVE_LIM) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end else if (bus.if_req) begin
               state_d      = BUSY_IF;
               owner_d      = 1'b0;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = bus.if_addr;
               starve_cnt_d = 4'd0;
            end
         end
         BUSY_IF: begin
            if (bus.mem_ack) begin
               state_d    = RESP;
               mem_req_d  = 1'b0;
               if_ready_d = 1'b1;
               if_rdata_d = bus.mem_rdata;
            end
         end
         BUSY_D: begin
            if (bus.mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               d_ready_d = 1'b1;
               if (!mem_we_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = bus.mem_rdata;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         owner_q      <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_ready_q   <= 1'b0;
         if_rdata_q   <= '0;
         d_ready_q    <= 1'b0;
         d_rvalid_q   <= 1'b0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_ready_q   <= if_ready_d;
         if_rdata_q   <= if_rdata_d;
         d_ready_q    <= d_ready_d;
         d_rvalid_q   <= d_rvalid_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked against a
// transaction-level model of the grant rule and the completion results.
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_starve;
   logic [31:0] exp_if_rdata;
   logic [31:0] exp_d_rdata;
   logic [31:0] exp_wdata;
   string       grants;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},   32'(bus.mem_req),  32'd0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),   32'd0);
      chk({tag, "_mem_addr"},  bus.mem_addr,      32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,     32'd0);
      chk({tag, "_if_ready"},  32'(bus.if_ready), 32'd0);
      chk({tag, "_if_rdata"},  bus.if_rdata,      32'd0);
      chk({tag, "_d_ready"},   32'(bus.d_ready),  32'd0);
      chk({tag, "_d_rvalid"},  32'(bus.d_rvalid), 32'd0);
      chk({tag, "_d_rdata"},   bus.d_rdata,       32'd0);
      chk({tag, "_busy"},      32'(bus.busy),     32'd0);
      chk({tag, "_owner"},     32'(bus.owner),    32'd0);
   endtask

   // Entered at a falling edge while the arbiter is idle, with at least one
   // request already driven. Acks after 'delay' extra wait cycles.
   task automatic round(input int delay, input logic [31:0] rd);
      logic        win_d;
      logic        ewe;
      logic [31:0] ea;
      // Data goes first unless fetch is waiting and data has already had
      // SMAX grants in a row while fetch waited.
      win_d = bus.d_req && (!bus.if_req || (m_starve < SMAX));
      if (win_d && bus.if_req) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      else                     m_starve = 0;
      ea  = win_d ? bus.d_addr : bus.if_addr;
      ewe = win_d ? bus.d_we : 1'b0;
      if (win_d) exp_wdata = bus.d_wdata;
      grants = {grants, win_d ? "D" : "F"};

      @(negedge clk);
      chk("grant_mem_req",   32'(bus.mem_req), 32'd1);
      chk("grant_owner",     32'(bus.owner),   32'(win_d));
      chk("grant_mem_addr",  bus.mem_addr,     ea);
      chk("grant_mem_we",    32'(bus.mem_we),  32'(ewe));
      chk("grant_mem_wdata", bus.mem_wdata,    exp_wdata);
      chk("grant_busy",      32'(bus.busy),    32'd1);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("wait_mem_req",  32'(bus.mem_req), 32'd1);
         chk("wait_mem_addr", bus.mem_addr,     ea);
         chk("wait_mem_we",   32'(bus.mem_we),  32'(ewe));
         chk("wait_if_ready", 32'(bus.if_ready | bus.d_ready), 32'd0);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;

      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!win_d)    exp_if_rdata = rd;
      else if (!ewe) exp_d_rdata  = rd;
      chk("resp_if_ready", 32'(bus.if_ready), 32'(!win_d));
      chk("resp_d_ready",  32'(bus.d_ready),  32'(win_d));
      chk("resp_d_rvalid", 32'(bus.d_rvalid), 32'(win_d && !ewe));
      chk("resp_if_rdata", bus.if_rdata,      exp_if_rdata);
      chk("resp_d_rdata",  bus.d_rdata,       exp_d_rdata);
      chk("resp_mem_req",  32'(bus.mem_req),  32'd0);
      chk("resp_busy",     32'(bus.busy),     32'd1);
      if (win_d) bus.d_req  = 1'b0;
      else       bus.if_req = 1'b0;

      @(negedge clk);
      chk("idle_ready",   32'(bus.if_ready | bus.d_ready | bus.d_rvalid), 32'd0);
      chk("idle_busy",    32'(bus.busy),    32'd0);
      chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      m_starve      = 0;
      exp_if_rdata  = '0;
      exp_d_rdata   = '0;
      exp_wdata     = '0;
      grants        = "";

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // Single fetch, immediate ack.
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      round(0, 32'hE3A0_1005);

      // Load acked on the third request cycle.
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h2000;
      round(2, 32'hDEAD_BEEF);

      // Store: no rvalid, d_rdata unchanged.
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h55;
      round(1, 32'h1234_5678);

      // Simultaneous requests: data first, then the waiting fetch.
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h104;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h44;
      round(0, 32'hA5A5_0001);
      chk("simul_owner_data", 32'(bus.owner), 32'd1);
      round(0, 32'hA5A5_0002);
      chk("simul_owner_fetch", 32'(bus.owner), 32'd0);

      // Starvation: both held continuously.
      grants = "";
      for (int r = 0; r < 6; r++) begin
         if (!bus.if_req) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!bus.d_req) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
         end
         round(0, $urandom);
      end
      n_checks++;
      assert (grants == "DDDDFD") else begin
         n_errors++;
         $error("FAIL starve_order: observed %s expected DDDDFD", grants);
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(negedge clk);
      chk("starve_quiet_busy", 32'(bus.busy), 32'd0);

      // Reset while a load is on the memory port; the late ack is ignored.
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h3000;
      @(negedge clk);
      chk("rst_pre_mem_req", 32'(bus.mem_req), 32'd1);
      reset     = 1'b1;
      bus.d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk_all_zero("rst_mid");
      m_starve     = 0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
      exp_wdata    = '0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("rst_late_ack_d_ready", 32'(bus.d_ready), 32'd0);
      chk("rst_late_ack_busy",    32'(bus.busy),    32'd0);
      chk("rst_late_ack_d_rdata", bus.d_rdata,      32'd0);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      round(1, 32'h0BAD_CAFE);

      // Spurious ack while idle.
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_0000;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("spur_busy",     32'(bus.busy), 32'd0);
      chk("spur_ready",    32'(bus.if_ready | bus.d_ready | bus.d_rvalid), 32'd0);
      chk("spur_if_rdata", bus.if_rdata, exp_if_rdata);
      chk("spur_d_rdata",  bus.d_rdata,  exp_d_rdata);
      @(negedge clk);
      chk("spur_busy_after", 32'(bus.busy), 32'd0);

      // Randomized traffic; a losing request stays held with stable fields.
      for (int r = 0; r < 40; r++) begin
         if (!bus.if_req && ($urandom_range(0, 9) < 6)) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom;
         end
         if (!bus.d_req && ($urandom_range(0, 9) < 6)) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
         end
         if (!bus.if_req && !bus.d_req) begin
            bus.if_req  = 1'b1;
            bus.if_addr = $urandom;
         end
         round(int'($urandom_range(0, 4)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch path and the load/store data path of the multicycle core.
- Grants one requester at a time, drives a registered memory request, waits a variable number of cycles for the memory acknowledge, then returns a one-cycle completion pulse and read data to the owner.
- Data accesses have priority. A starvation counter forces a fetch grant after a bounded run of data grants.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive data grants, taken while if_req is pending, after which fetch wins the next arbitration. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse to data path.
- d_rvalid  out  1  pulses together with d_ready for loads only.
- d_rdata  out  DATA_W  load data; valid when d_rvalid=1.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory completion; one-cycle pulse, honoured only while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = fetch, 1 = data; last granted requester.

Behaviour:
- Reset:
  - state = IDLE, starve_cnt = 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, d_ready, d_rvalid, d_rdata, busy, owner.
- Reset taking effect mid-transaction:
  - mem_req drops on the next edge.
  - No ready pulse is issued.
  - A later mem_ack is ignored.
- States: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE, arbitration:
  - If d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX): grant data, owner=1, go BUSY_D.
  - Else if if_req=1: grant fetch, owner=0, go BUSY_IF.
  - On the grant edge, capture mem_addr/mem_we/mem_wdata and set mem_req=1. For fetch, mem_we=0 and mem_wdata is held.
  - No request: stay in IDLE.
- starve_cnt, updated on each grant:
  - Data grant with if_req=1: increment, saturating at STARVE_MAX.
  - Fetch grant: clear to 0.
  - Data grant with if_req=0: clear to 0.
- BUSY_IF / BUSY_D:
  - mem_req and all mem_* fields are held constant.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register, clear mem_req, go RESP.
  - On the same edge:
    - fetch owner: if_ready=1.
    - data owner: d_ready=1, and d_rvalid=1 if mem_we=0.
  - No timeout; the arbiter waits indefinitely.
- RESP:
  - Ready/rvalid are high for exactly this one cycle.
  - Requests are not sampled in this cycle.
  - Next state is always IDLE, where ready/rvalid clear.
- rdata registers:
  - Hold their value until the next completion for the same owner.
  - Stores do not update d_rdata.
- mem_ack while in IDLE or RESP: ignored, with no state change.
- Minimum transaction timing:
  - request sampled in IDLE, cycle 0
  - mem_req high, cycle 1 (ack may arrive here)
  - ready pulse, cycle 2 (RESP)
  - next arbitration, cycle 3
- Requester obligation: drop or replace req on the edge where it sees its ready. A req still high in the following IDLE cycle is treated as a new request.
- The arbiter never issues two memory requests back-to-back without passing through RESP and IDLE. At most one transaction is outstanding.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack on the 1st mem_req cycle with mem_rdata=0xE3A01005 -> mem_req high for 1 cycle with mem_addr=0x100, mem_we=0; if_ready pulses 1 cycle later with if_rdata=0xE3A01005; d_ready stays 0.
- Load with 3-cycle wait: d_req=1, d_we=0, d_addr=0x2000, ack on the 3rd mem_req cycle with rdata=0xDEADBEEF -> mem_req high 3 cycles with fields stable; d_ready=d_rvalid=1 for one cycle; d_rdata=0xDEADBEEF.
- Store then simultaneous requests: store 0x55 to 0x40 -> d_ready=1, d_rvalid=0, mem_wdata=0x55. Then if_req=d_req=1 together -> data granted first (owner=1).
- Starvation: hold if_req=1 and d_req=1 continuously, immediate acks -> grant order D,D,D,D,F,D,... for STARVE_MAX=4; starve_cnt returns to 0 after the fetch grant.
- Reset during BUSY_D: assert reset 1 cycle while mem_req=1, then mem_ack arrives -> mem_req=0 after the reset edge; no d_ready pulse; all outputs 0; the next if_req is served normally.
- Spurious ack: mem_ack=1 while in IDLE with no requests -> no ready pulse, busy stays 0, rdata registers unchanged.
